// File: rtl/xil_mem_sp_1024x16_ctl.sv
// Requester-side controller for a 1024x16 byte-writable single-port BRAM:
// valid/ready request port, 2-entry read-response FIFO, and a full-memory init sweep.
module xil_mem_sp_1024x16_ctl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init,
    input  logic [15:0] i_init_data,
    output logic        o_init_busy,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wr,
    input  logic [1:0]  i_req_be,
    input  logic [9:0]  i_req_adr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_data,
    output logic        o_mem_en,
    output logic [1:0]  o_mem_wen,
    output logic [9:0]  o_mem_adr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  sweep_cnt;
    logic [15:0] init_val;
    logic        rd_inflight;
    logic [15:0] fifo_mem [2];
    logic        fifo_wr_ptr;
    logic        fifo_rd_ptr;
    logic [1:0]  fifo_cnt;
    logic        push;
    logic        pop;
    logic        accept;
    logic        req_ready;
    logic [2:0]  occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_init) state_nxt = INIT;
            INIT:    if (sweep_cnt == 10'd1023) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt <= 10'd0;
            init_val  <= 16'd0;
        end else if (state == IDLE && i_init) begin
            sweep_cnt <= 10'd0;
            init_val  <= i_init_data;
        end else if (state == INIT) begin
            sweep_cnt <= sweep_cnt + 10'd1;
        end
    end

    // Credits count both buffered responses and the read whose data arrives next
    // cycle, so the FIFO can never be pushed while full.
    assign pop       = o_rsp_valid & i_rsp_ready;
    assign push      = rd_inflight;
    assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign req_ready = rst_n & (state == IDLE) & ~i_init & (occ < 3'd2);
    assign accept    = i_req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= accept & ~i_req_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= 16'd0;
            fifo_mem[1] <= 16'd0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= i_mem_rdata;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign o_rsp_valid = (fifo_cnt != 2'd0);
    assign o_rsp_data  = fifo_mem[fifo_rd_ptr];
    assign o_req_ready = req_ready;
    assign o_init_busy = (state == INIT);

    // Memory pins are held at zero during reset even though the request path is combinational.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_wen   = 2'b00;
        o_mem_adr   = 10'd0;
        o_mem_wdata = 16'd0;
        if (rst_n) begin
            if (state == INIT) begin
                o_mem_en    = 1'b1;
                o_mem_wen   = 2'b11;
                o_mem_adr   = sweep_cnt;
                o_mem_wdata = init_val;
            end else begin
                o_mem_en    = accept;
                o_mem_wen   = (accept & i_req_wr) ? i_req_be : 2'b00;
                o_mem_adr   = i_req_adr;
                o_mem_wdata = i_req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_xil_mem_sp_1024x16_ctl.sv
// Directed bench for xil_mem_sp_1024x16_ctl with a behavioural 1024x16 BRAM
// attached to the memory pins; responses are captured into queues on the falling edge.
module tb_xil_mem_sp_1024x16_ctl;

    logic        clk;
    logic        rst_n;
    logic        i_init;
    logic [15:0] i_init_data;
    logic        o_init_busy;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wr;
    logic [1:0]  i_req_be;
    logic [9:0]  i_req_adr;
    logic [15:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [15:0] o_rsp_data;
    logic        o_mem_en;
    logic [1:0]  o_mem_wen;
    logic [9:0]  o_mem_adr;
    logic [15:0] o_mem_wdata;
    logic [15:0] i_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] bram    [1024];
    logic [15:0] ref_mem [1024];
    logic [15:0] rsp_data_q [$];
    int          rsp_cyc_q  [$];
    logic [15:0] exp_q      [$];

    xil_mem_sp_1024x16_ctl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_init      (i_init),
        .i_init_data (i_init_data),
        .o_init_busy (o_init_busy),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_wr    (i_req_wr),
        .i_req_be    (i_req_be),
        .i_req_adr   (i_req_adr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_mem_en    (o_mem_en),
        .o_mem_wen   (o_mem_wen),
        .o_mem_adr   (o_mem_adr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: read-before-write, one-cycle read latency, byte lanes.
    initial begin
        foreach (bram[i]) bram[i] = 16'h0000;
        i_mem_rdata = 16'h0000;
    end
    always @(posedge clk) begin
        if (o_mem_en) begin
            i_mem_rdata <= bram[o_mem_adr];
            if (o_mem_wen[0]) bram[o_mem_adr][7:0]  <= o_mem_wdata[7:0];
            if (o_mem_wen[1]) bram[o_mem_adr][15:8] <= o_mem_wdata[15:8];
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_rsp_valid && i_rsp_ready) begin
            rsp_data_q.push_back(o_rsp_data);
            rsp_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Holds a request until accepted; caller is just after a rising edge.
    task automatic do_req(input bit wr, input logic [1:0] be, input logic [9:0] adr,
                          input logic [15:0] wd, output int acc);
        bit ok;
        ok = 0;
        acc = -1;
        i_req_valid = 1'b1;
        i_req_wr    = wr;
        i_req_be    = be;
        i_req_adr   = adr;
        i_req_wdata = wd;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (o_req_ready) begin
                ok  = 1;
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL req_accept_timeout: adr=%0d got not accepted, required accepted", adr);
        end
    endtask

    task automatic wait_rsp(output logic [15:0] d, output int c);
        bit ok;
        ok = 0;
        d  = 16'h0000;
        c  = -1;
        for (int i = 0; i < 50; i++) begin
            if (rsp_data_q.size() > 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (ok) begin
            d = rsp_data_q.pop_front();
            c = rsp_cyc_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        i_init      = 1'b0;
        i_init_data = 16'h0000;
        i_req_valid = 1'b1;
        i_req_wr    = 1'b1;
        i_req_be    = 2'b11;
        i_req_adr   = 10'h3FF;
        i_req_wdata = 16'hFFFF;
        i_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (o_mem_en !== 1'b0)        begin n_fail++; $display("[TB] FAIL reset_mem_en: got %b required 0", o_mem_en); end
        n_checks++; if (o_mem_wen !== 2'b00)      begin n_fail++; $display("[TB] FAIL reset_mem_wen: got %b required 00", o_mem_wen); end
        n_checks++; if (o_mem_adr !== 10'd0)      begin n_fail++; $display("[TB] FAIL reset_mem_adr: got %h required 000", o_mem_adr); end
        n_checks++; if (o_mem_wdata !== 16'd0)    begin n_fail++; $display("[TB] FAIL reset_mem_wdata: got %h required 0000", o_mem_wdata); end
        n_checks++; if (o_rsp_valid !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b required 0", o_rsp_valid); end
        n_checks++; if (o_rsp_data !== 16'd0)     begin n_fail++; $display("[TB] FAIL reset_rsp_data: got %h required 0000", o_rsp_data); end
        n_checks++; if (o_init_busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_init_busy: got %b required 0", o_init_busy); end
        n_checks++; if (o_req_ready !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b required 0", o_req_ready); end
        i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 1'b1)     begin n_fail++; $display("[TB] FAIL post_reset_ready: got %b required 1", o_req_ready); end
        n_checks++; if (o_rsp_valid !== 1'b0)     begin n_fail++; $display("[TB] FAIL post_reset_rsp_valid: got %b required 0", o_rsp_valid); end
    endtask

    task automatic test_write_read();
        logic [15:0] d;
        int c;
        int t;
        @(posedge clk);
        #1;
        i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_be = 2'b11; i_req_adr = 10'd5; i_req_wdata = 16'hBEEF;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 1'b1)     begin n_fail++; $display("[TB] FAIL wr_ready: got %b required 1", o_req_ready); end
        n_checks++; if (o_mem_en !== 1'b1)        begin n_fail++; $display("[TB] FAIL wr_mem_en: got %b required 1", o_mem_en); end
        n_checks++; if (o_mem_wen !== 2'b11)      begin n_fail++; $display("[TB] FAIL wr_mem_wen: got %b required 11", o_mem_wen); end
        n_checks++; if (o_mem_adr !== 10'd5)      begin n_fail++; $display("[TB] FAIL wr_mem_adr: got %0d required 5", o_mem_adr); end
        n_checks++; if (o_mem_wdata !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL wr_mem_wdata: got %h required beef", o_mem_wdata); end
        @(posedge clk);
        #1;
        i_req_wr = 1'b0;
        @(negedge clk);
        t = cyc;
        n_checks++; if (o_mem_en !== 1'b1)        begin n_fail++; $display("[TB] FAIL rd_mem_en: got %b required 1", o_mem_en); end
        n_checks++; if (o_mem_wen !== 2'b00)      begin n_fail++; $display("[TB] FAIL rd_mem_wen: got %b required 00", o_mem_wen); end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        wait_rsp(d, c);
        n_checks++; if (d !== 16'hBEEF)           begin n_fail++; $display("[TB] FAIL rd_data: got %h required beef", d); end
        n_checks++; if (c !== t + 2)              begin n_fail++; $display("[TB] FAIL rd_latency: got cycle %0d required %0d", c, t + 2); end
        repeat (3) @(negedge clk);
        n_checks++; if (rsp_data_q.size() !== 0)  begin n_fail++; $display("[TB] FAIL rd_one_pulse: got %0d extra responses required 0", rsp_data_q.size()); end
    endtask

    task automatic test_byte_enables();
        logic [15:0] d;
        int c;
        int a;
        @(posedge clk);
        #1;
        do_req(1'b1, 2'b11, 10'd9, 16'h1234, a);
        do_req(1'b1, 2'b10, 10'd9, 16'hAB00, a);
        do_req(1'b0, 2'b00, 10'd9, 16'h0000, a);
        wait_rsp(d, c);
        n_checks++; if (d !== 16'hAB34)           begin n_fail++; $display("[TB] FAIL be_upper: got %h required ab34", d); end
        @(posedge clk);
        #1;
        do_req(1'b1, 2'b00, 10'd9, 16'hFFFF, a);
        do_req(1'b0, 2'b11, 10'd9, 16'h0000, a);
        wait_rsp(d, c);
        n_checks++; if (d !== 16'hAB34)           begin n_fail++; $display("[TB] FAIL be_none: got %h required ab34", d); end
        repeat (3) @(negedge clk);
        n_checks++; if (rsp_data_q.size() !== 0)  begin n_fail++; $display("[TB] FAIL be_no_write_rsp: got %0d extra responses required 0", rsp_data_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        int c;
        int first_c;
        int a;
        int idx;
        int accepted;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) do_req(1'b1, 2'b11, 10'(i), 16'h1000 + 16'(i), a);
        i_rsp_ready = 1'b0;
        idx = 0;
        accepted = 0;
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_adr = 10'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_req_ready) begin
                accepted++;
                idx++;
            end
            @(posedge clk);
            #1;
            i_req_adr = 10'(idx);
        end
        n_checks++; if (accepted !== 2)           begin n_fail++; $display("[TB] FAIL bp_accepted: got %0d required 2", accepted); end
        n_checks++; if (o_req_ready !== 1'b0)     begin n_fail++; $display("[TB] FAIL bp_ready_low: got %b required 0", o_req_ready); end
        n_checks++; if (o_rsp_valid !== 1'b1)     begin n_fail++; $display("[TB] FAIL bp_rsp_held: got %b required 1", o_rsp_valid); end
        n_checks++; if (o_rsp_data !== 16'h1000)  begin n_fail++; $display("[TB] FAIL bp_rsp_stable: got %h required 1000", o_rsp_data); end
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            @(negedge clk);
            if (o_req_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 4) i_req_adr = 10'(idx);
            else i_req_valid = 1'b0;
        end
        i_req_valid = 1'b0;
        first_c = -1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(d, c);
            if (k == 0) first_c = c;
            n_checks++; if (d !== 16'h1000 + 16'(k)) begin n_fail++; $display("[TB] FAIL bp_order_%0d: got %h required %h", k, d, 16'h1000 + 16'(k)); end
            n_checks++; if (c !== first_c + k)       begin n_fail++; $display("[TB] FAIL bp_gapless_%0d: got cycle %0d required %0d", k, c, first_c + k); end
        end
    endtask

    task automatic test_init();
        logic [15:0] d;
        int c;
        int a;
        int busy_cnt;
        int en_cnt;
        int rdy_seen;
        logic [9:0] first_adr;
        logic [9:0] last_adr;
        @(posedge clk);
        #1;
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_adr = 10'd5;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 1'b1)     begin n_fail++; $display("[TB] FAIL init_pre_read_ready: got %b required 1", o_req_ready); end
        @(posedge clk);
        #1;
        i_init = 1'b1; i_init_data = 16'h5A5A; i_req_adr = 10'd9;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 1'b0)     begin n_fail++; $display("[TB] FAIL init_wins_ready: got %b required 0", o_req_ready); end
        n_checks++; if (o_mem_en !== 1'b0)        begin n_fail++; $display("[TB] FAIL init_wins_mem_en: got %b required 0", o_mem_en); end
        n_checks++; if (o_init_busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL init_busy_early: got %b required 0", o_init_busy); end
        @(posedge clk);
        #1;
        i_init = 1'b0; i_init_data = 16'h0000; i_req_valid = 1'b0;
        busy_cnt = 0; en_cnt = 0; rdy_seen = 0; first_adr = 10'h3AA; last_adr = 10'h3AA;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (!o_init_busy) break;
            if (busy_cnt == 0) first_adr = o_mem_adr;
            last_adr = o_mem_adr;
            if (o_mem_en && o_mem_wen == 2'b11 && o_mem_wdata == 16'h5A5A) en_cnt++;
            if (o_req_ready) rdy_seen++;
            busy_cnt++;
            i_init = (busy_cnt == 500);
        end
        i_init = 1'b0;
        n_checks++; if (busy_cnt !== 1024)        begin n_fail++; $display("[TB] FAIL init_busy_len: got %0d required 1024", busy_cnt); end
        n_checks++; if (en_cnt !== 1024)          begin n_fail++; $display("[TB] FAIL init_mem_writes: got %0d required 1024", en_cnt); end
        n_checks++; if (rdy_seen !== 0)           begin n_fail++; $display("[TB] FAIL init_ready_blocked: got %0d ready cycles required 0", rdy_seen); end
        n_checks++; if (first_adr !== 10'd0)      begin n_fail++; $display("[TB] FAIL init_first_adr: got %0d required 0", first_adr); end
        n_checks++; if (last_adr !== 10'd1023)    begin n_fail++; $display("[TB] FAIL init_last_adr: got %0d required 1023", last_adr); end
        n_checks++; if (o_req_ready !== 1'b1)     begin n_fail++; $display("[TB] FAIL init_ready_return: got %b required 1", o_req_ready); end
        wait_rsp(d, c);
        n_checks++; if (d !== 16'hBEEF)           begin n_fail++; $display("[TB] FAIL init_inflight_old: got %h required beef", d); end
        n_checks++; if (rsp_data_q.size() !== 0)  begin n_fail++; $display("[TB] FAIL init_blocked_req: got %0d extra responses required 0", rsp_data_q.size()); end
        @(posedge clk);
        #1;
        do_req(1'b0, 2'b00, 10'd0, 16'h0000, a);
        do_req(1'b0, 2'b00, 10'd511, 16'h0000, a);
        do_req(1'b0, 2'b00, 10'd1023, 16'h0000, a);
        for (int k = 0; k < 3; k++) begin
            wait_rsp(d, c);
            n_checks++; if (d !== 16'h5A5A)       begin n_fail++; $display("[TB] FAIL init_fill_%0d: got %h required 5a5a", k, d); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [15:0] d;
        int c;
        int a;
        @(posedge clk);
        #1;
        i_init = 1'b1; i_init_data = 16'h1111;
        @(posedge clk);
        #1;
        i_init = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        n_checks++; if (o_init_busy !== 1'b1)     begin n_fail++; $display("[TB] FAIL mid_sweep_busy: got %b required 1", o_init_busy); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_init_busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL async_busy: got %b required 0", o_init_busy); end
        n_checks++; if (o_mem_en !== 1'b0)        begin n_fail++; $display("[TB] FAIL async_mem_en: got %b required 0", o_mem_en); end
        n_checks++; if (o_mem_wen !== 2'b00)      begin n_fail++; $display("[TB] FAIL async_mem_wen: got %b required 00", o_mem_wen); end
        n_checks++; if (o_mem_adr !== 10'd0)      begin n_fail++; $display("[TB] FAIL async_mem_adr: got %0d required 0", o_mem_adr); end
        n_checks++; if (o_mem_wdata !== 16'd0)    begin n_fail++; $display("[TB] FAIL async_mem_wdata: got %h required 0000", o_mem_wdata); end
        n_checks++; if (o_req_ready !== 1'b0)     begin n_fail++; $display("[TB] FAIL async_ready: got %b required 0", o_req_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_data_q.delete();
        rsp_cyc_q.delete();
        @(negedge clk);
        n_checks++; if (o_req_ready !== 1'b1)     begin n_fail++; $display("[TB] FAIL after_abort_ready: got %b required 1", o_req_ready); end
        n_checks++; if (o_init_busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL after_abort_busy: got %b required 0", o_init_busy); end
        @(posedge clk);
        #1;
        do_req(1'b0, 2'b00, 10'd10, 16'h0000, a);
        do_req(1'b0, 2'b00, 10'd1000, 16'h0000, a);
        wait_rsp(d, c);
        n_checks++; if (d !== 16'h1111)           begin n_fail++; $display("[TB] FAIL abort_swept_word: got %h required 1111", d); end
        wait_rsp(d, c);
        n_checks++; if (d !== 16'h5A5A)           begin n_fail++; $display("[TB] FAIL abort_unswept_word: got %h required 5a5a", d); end
    endtask

    task automatic test_random_mix();
        logic [15:0] d;
        int a;
        int ops;
        bit pending;
        logic [9:0] adr;
        logic [15:0] wd;
        logic [1:0] be;
        bit wr;
        @(posedge clk);
        #1;
        for (int i = 16; i < 32; i++) begin
            ref_mem[i] = 16'hC000 + 16'(i * 37);
            do_req(1'b1, 2'b11, 10'(i), ref_mem[i], a);
        end
        ops = 0;
        pending = 0;
        for (int k = 0; k < 600; k++) begin
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            if (!pending && ops < 200 && $urandom_range(0, 3) != 0) begin
                wr  = $urandom_range(0, 1);
                be  = 2'($urandom_range(0, 3));
                adr = 10'($urandom_range(16, 31));
                wd  = 16'($urandom);
                i_req_valid = 1'b1; i_req_wr = wr; i_req_be = be; i_req_adr = adr; i_req_wdata = wd;
                pending = 1;
            end
            @(negedge clk);
            #1;
            while (rsp_data_q.size() > 0) begin
                d = rsp_data_q.pop_front();
                void'(rsp_cyc_q.pop_front());
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL rand_unexpected_rsp: got %h required no response", d);
                end else if (d !== exp_q[0]) begin
                    n_fail++; $display("[TB] FAIL rand_rsp_data: got %h required %h", d, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (pending && o_req_ready) begin
                if (wr) begin
                    if (be[0]) ref_mem[adr][7:0]  = wd[7:0];
                    if (be[1]) ref_mem[adr][15:8] = wd[15:8];
                end else begin
                    exp_q.push_back(ref_mem[adr]);
                end
                pending = 0;
                ops++;
            end
            n_checks++; if (exp_q.size() > 2)     begin n_fail++; $display("[TB] FAIL rand_outstanding: got %0d required at most 2", exp_q.size()); end
            @(posedge clk);
            #1;
            if (!pending) i_req_valid = 1'b0;
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            while (rsp_data_q.size() > 0) begin
                d = rsp_data_q.pop_front();
                void'(rsp_cyc_q.pop_front());
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("[TB] FAIL rand_drain_unexpected: got %h required no response", d);
                end else begin
                    if (d !== exp_q[0]) begin n_fail++; $display("[TB] FAIL rand_drain_data: got %h required %h", d, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
        end
        n_checks++; if (exp_q.size() !== 0)       begin n_fail++; $display("[TB] FAIL rand_all_returned: got %0d missing required 0", exp_q.size()); end
        n_checks++; if (ops < 100)                begin n_fail++; $display("[TB] FAIL rand_ops_done: got %0d required at least 100", ops); end
    endtask

    initial begin
        $display("[TB] starting xil_mem_sp_1024x16_ctl bench");
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_init();
        test_reset_mid_sweep();
        test_random_mix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xil_mem_sp_1024x16_ctl.md
# xil_mem_sp_1024x16_ctl

Requester-side controller for the 1024x16 single-port byte-writable BRAM. It accepts read and write requests from a client over a valid/ready handshake and drives the memory's enable, byte-write-enable, address and write-data pins. It captures the memory's one-cycle read data into a 2-entry response FIFO with backpressure, and provides a hardware init sweep that fills all 1024 words with a given value. It sits between any block-level client and the memory instance.

## Interface
- No parameters; geometry fixed at 1024 words x 16 bits, 2 byte lanes.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_init  in  1  pulse; starts an init sweep when the controller is idle.
- i_init_data  in  16  value written to every word during the sweep; sampled on the accepting cycle.
- o_init_busy  out  1  high for the 1024 sweep cycles.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_wr  in  1  1=write, 0=read.
- i_req_be  in  2  write byte enables; bit0=[7:0], bit1=[15:8]; ignored for reads.
- i_req_adr  in  10  word address.
- i_req_wdata  in  16  write data.
- o_rsp_valid  out  1  read response valid.
- i_rsp_ready  in  1  response consumed when valid&ready.
- o_rsp_data  out  16  read data, in request order.
- o_mem_en  out  1  to memory i_en.
- o_mem_wen  out  2  to memory i_wen.
- o_mem_adr  out  10  to memory i_adr.
- o_mem_wdata  out  16  to memory i_wdata.
- i_mem_rdata  in  16  from memory o_rdata; valid the cycle after o_mem_en.

## Operation
- States: IDLE, INIT.
  - IDLE->INIT: i_init=1. Latch i_init_data and clear the sweep counter.
  - INIT->IDLE: after the cycle with counter=1023.
  - i_init while in INIT is ignored.
- IDLE memory drive is combinational from the accepted request:
  - o_mem_en = i_req_valid & o_req_ready.
  - o_mem_wen = i_req_wr ? i_req_be : 2'b00.
  - o_mem_adr = i_req_adr.
  - o_mem_wdata = i_req_wdata.
  - With no acceptance, o_mem_en=0 and o_mem_wen=0.
- Writes with i_req_be=00 are accepted and produce no response; the memory is enabled but no byte is written.
- INIT memory drive: o_mem_en=1, o_mem_wen=2'b11, o_mem_adr=counter, o_mem_wdata=latched value. The counter increments 0..1023.
- Credit rule: occ = fifo_count + rd_inflight - (o_rsp_valid & i_rsp_ready).
  - o_req_ready = (state==IDLE) & ~i_init & (occ < 2).
  - o_req_ready depends on neither i_req_valid nor i_req_wr.
- rd_inflight is set on the cycle after an accepted read, and the FIFO pushes i_mem_rdata in that same cycle.
- The memory updates its o_rdata on writes too, so only reads push data.
- Response FIFO: 2 entries, in-order. It never overflows, which is guaranteed by the credit rule. Simultaneous push and pop at count 2 cannot occur; at count 1 the count is unchanged.
- Reads already in flight when an init starts still complete and drain normally.
- A read accepted before the sweep returns the pre-init contents.
- Reset values: o_mem_en=0, o_mem_wen=0, o_mem_adr=0, o_mem_wdata=0, o_rsp_valid=0, o_rsp_data=0, o_init_busy=0, o_req_ready=0 while rst_n=0.
- After reset: state=IDLE, FIFO empty, no read in flight.
- Reset mid-sweep or mid-read aborts immediately; pending responses are lost. Memory contents are not reset.

## Timing
- Read latency: accepted in cycle t -> memory samples at end of t -> FIFO push at end of t+1 -> o_rsp_valid in t+2 (FIFO empty, i_rsp_ready=1).
- Write: takes effect at the end of the accepting cycle. A read of the same address in t+1 returns the new data.
- Throughput: one request per cycle sustained while i_rsp_ready=1.
  - With i_rsp_ready=0, at most 2 reads are accepted; o_req_ready then drops and blocks writes too.
  - o_req_ready rises in the same cycle as a pop.
- Init: o_init_busy rises the cycle after i_init is sampled and stays high for exactly 1024 cycles.
  - o_mem_en=1 in each of those cycles.
  - o_req_ready is low from the i_init cycle through the last sweep cycle, then returns the next cycle.
- i_init together with i_req_valid in IDLE: init wins and the request is not accepted.
- The response holds stable while o_rsp_valid=1 and i_rsp_ready=0.

## Test plan
- Reset then write adr 5 = 0xBEEF with be=11, then read adr 5 -> o_rsp_valid 2 cycles after the read is accepted, o_rsp_data=0xBEEF, one pulse.
- Write 0x1234 to adr 9, then write 0xAB00 to adr 9 with be=10, then read adr 9 -> 0xAB34. Write with be=00, then read -> still 0xAB34.
- i_rsp_ready=0 with 4 back-to-back reads of adr 0..3 -> only 2 accepted, then o_req_ready=0. Raise i_rsp_ready -> all 4 responses returned in order with no gaps.
- Assert i_init with i_init_data=0x5A5A during a read burst -> the request on that cycle is not accepted and o_init_busy is high for 1024 cycles. Reads of adr 0, 511 and 1023 afterwards -> 0x5A5A. An in-flight pre-init read returns old data.
- Assert rst_n low mid-sweep at counter ~300 -> all outputs go to reset values asynchronously, and after release the controller is IDLE with o_req_ready=1.
- Random mix of reads, writes and byte enables against a reference model, with random i_rsp_ready -> every response matches and the FIFO never overflows.
